add_sub_arbiter: RTL

Round-robin arbiter and sequencer that shares one `add_sub` datapath (nBit-wide add/subtract with carry-out) among four requesters. Each requester presents two operands and an add/subtract select; the block grants one requester at a time, latches its operands, drives the shared `add_sub` instance for one execute cycle, and returns the registered result with a requester ID over a valid/ready handshake. It sits between the ALU-using control units and the single shared adder/subtractor.

---
 rtl/add_sub_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/add_sub_arbiter.sv
// ---------------------------------------------------------------------------
// add_sub / add_sub_arbiter
//
// add_sub: nBit-wide adder/subtractor with carry-out.
//   a, b  : operands
//   cond  : 1 = a - b (two's-complement negate b, then add), 0 = a + b
//   out   : (a + b') mod 2^nBit
//   cout  : carry out of bit nBit-1 of that addition
//
// add_sub_arbiter: round-robin front end that shares one add_sub among four
// requesters and hands back one registered result at a time.
//   clk, rst    : clock and synchronous active-high reset
//   req[3:0]    : per-requester request
//   op_a, op_b  : flat operands, requester i at [i*nBit +: nBit]
//   op_sub[3:0] : per-requester subtract select
//   gnt[3:0]    : one-hot grant, high in the cycle the operands are sampled
//   res_valid   : result pending
//   res_ready   : consumer accepts the pending result
//   res_data    : result value
//   res_cout    : adder carry-out
//   res_id      : index of the requester that produced the result
// ---------------------------------------------------------------------------

module add_sub #(
    parameter int nBit = 16
) (
    input  logic [nBit-1:0] a,
    input  logic [nBit-1:0] b,
    input  logic            cond,
    output logic [nBit-1:0] out,
    output logic            cout
);

    logic [nBit-1:0] b_eff;
    logic [nBit:0]   sum;

    // Subtraction reuses the adder by feeding it the two's complement of b.
    // With b = 0 the negated value wraps back to 0, so the carry-out is 0.
    always_comb begin
        b_eff = cond ? (~b + {{(nBit-1){1'b0}}, 1'b1}) : b;
        sum   = {1'b0, a} + {1'b0, b_eff};
    end

    assign out  = sum[nBit-1:0];
    assign cout = sum[nBit];

endmodule

module add_sub_arbiter #(
    parameter int nBit = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [4*nBit-1:0] op_a,
    input  logic [4*nBit-1:0] op_b,
    input  logic [3:0]        op_sub,
    output logic [3:0]        gnt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [nBit-1:0]   res_data,
    output logic              res_cout,
    output logic [1:0]        res_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]      state;
    logic [1:0]      ptr;
    logic [1:0]      win_id;
    logic            win_found;
    logic [1:0]      scan_idx;
    logic [nBit-1:0] a_arr [4];
    logic [nBit-1:0] b_arr [4];
    logic [nBit-1:0] lat_a;
    logic [nBit-1:0] lat_b;
    logic            lat_sub;
    logic [1:0]      lat_id;
    logic [nBit-1:0] sum_out;
    logic            sum_cout;

    // Unpack the flat operand buses so the winner can be selected by index.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = op_a[i*nBit +: nBit];
            b_arr[i] = op_b[i*nBit +: nBit];
        end
    end

    // Scan requesters starting at the round-robin pointer and wrapping
    // modulo 4; the first asserted request found wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr;
        scan_idx  = ptr;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr + 2'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    // The grant is combinational and only ever issued from IDLE, so nothing
    // new is accepted while a result is executing or waiting to be taken.
    // Reset suppresses it so no requester believes it was served.
    always_comb begin
        gnt = 4'b0000;
        if (state == IDLE && !rst && win_found) begin
            gnt[win_id] = 1'b1;
        end
    end

    add_sub #(
        .nBit (nBit)
    ) u_add_sub (
        .a    (lat_a),
        .b    (lat_b),
        .cond (lat_sub),
        .out  (sum_out),
        .cout (sum_cout)
    );

    // Sequencer: IDLE latches the granted operands, EXEC registers the
    // adder output, HOLD waits for the consumer. The pointer moves past the
    // served requester only when its result is accepted, which is what
    // bounds the wait of a continuously requesting requester to 3 grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_sub   <= 1'b0;
            lat_id    <= 2'd0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            res_id    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        lat_a   <= a_arr[win_id];
                        lat_b   <= b_arr[win_id];
                        lat_sub <= op_sub[win_id];
                        lat_id  <= win_id;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= sum_out;
                    res_cout  <= sum_cout;
                    res_id    <= lat_id;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= lat_id + 2'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
